// File: rtl/owr_pkg.sv
// ============================================================================
// Package : owr_pkg
// Desc    : Shared encodings for the one-wire temperature sequencer:
//           byte-master command ops, DS18B20 function codes, error codes,
//           sequencer state enum and the byte-serial Dallas CRC-8 step.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package owr_pkg;

  // Command opcodes presented to the byte-level one-wire master
  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  // ROM / function command bytes
  localparam logic [7:0] CMD_SKIP_ROM = 8'hCC;
  localparam logic [7:0] CMD_CONVERT  = 8'h44;
  localparam logic [7:0] CMD_READ_SP  = 8'hBE;

  // Error codes reported on err_code
  localparam logic [1:0] ERR_NONE        = 2'b00;
  localparam logic [1:0] ERR_NO_PRESENCE = 2'b01;
  localparam logic [1:0] ERR_CRC         = 2'b10;
  localparam logic [1:0] ERR_STUCK       = 2'b11;

  // Scratchpad length (8 data bytes + CRC byte)
  localparam int SCRATCH_BYTES = 9;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_RST1  = 4'd1,
    S_SKIP1 = 4'd2,
    S_CONV  = 4'd3,
    S_WAIT  = 4'd4,
    S_RST2  = 4'd5,
    S_SKIP2 = 4'd6,
    S_RDCMD = 4'd7,
    S_READ  = 4'd8,
    S_CHECK = 4'd9,
    S_DONE  = 4'd10,
    S_ERR   = 4'd11
  } state_t;

  // One byte of Dallas/Maxim CRC-8 (x^8+x^5+x^4+1, reflected, LSB first)
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 8'h8C;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/owr_crc8.sv
// ============================================================================
// Module : owr_crc8
// Desc   : Byte-serial Dallas/Maxim CRC-8 accumulator. clr has priority
//          over en; the running value is visible on crc the cycle after.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module owr_crc8
  import owr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] crc
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  // Next CRC value: clear, fold in one byte, or hold
  always_comb begin
    crc_d = crc_q;
    if (clr)     crc_d = 8'h00;
    else if (en) crc_d = crc8_step(crc_q, data);
  end

  // CRC register
  always_ff @(posedge clk) begin
    if (rst) crc_q <= 8'h00;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

`default_nettype wire

// File: rtl/owr_temp_sequencer.sv
// ============================================================================
// Module : owr_temp_sequencer
// Desc   : Sequences a byte-level one-wire master through a DS18B20
//          measurement (reset, SKIP ROM, CONVERT T, wait, reset, SKIP ROM,
//          READ SCRATCHPAD x9), checks the scratchpad and publishes the raw
//          16-bit temperature.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module owr_temp_sequencer
  import owr_pkg::*;
#(
  parameter int CONV_WAIT_CYCLES = 9000000,
  parameter int AUTO_PERIOD      = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic [15:0] temp,
  output logic        temp_valid,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        cmd_valid,
  output logic [1:0]  cmd_op,
  output logic [7:0]  cmd_data,
  input  logic        cmd_ready,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_data,
  input  logic        rsp_presence
);

  localparam logic [31:0] WAIT_LAST = 32'(CONV_WAIT_CYCLES - 1);
  localparam logic [31:0] AUTO_LAST = 32'(AUTO_PERIOD - 1);
  localparam logic        AUTO_EN   = (AUTO_PERIOD != 0);
  localparam logic [3:0]  IDX_LAST  = 4'(SCRATCH_BYTES - 1);

  state_t                          state_q, state_d;
  logic                            pend_q, pend_d;      // command accepted, awaiting rsp_valid
  logic [3:0]                      idx_q, idx_d;        // scratchpad byte index
  logic [31:0]                     wait_q, wait_d;      // conversion wait counter
  logic [31:0]                     auto_q, auto_d;      // auto-restart counter
  logic [15:0]                     temp_q, temp_d;
  logic [1:0]                      err_code_q, err_code_d;
  logic [SCRATCH_BYTES-1:0][7:0]   scratch_q, scratch_d;

  logic       cmd_state;
  logic       rsp_done;
  logic       all_zero;
  logic       crc_clr;
  logic       crc_en;
  logic [7:0] crc_val;

  owr_crc8 u_crc (
    .clk  (clk),
    .rst  (rst),
    .clr  (crc_clr),
    .en   (crc_en),
    .data (rsp_data),
    .crc  (crc_val)
  );

  // States that own a bus command; a response only counts while one is outstanding
  assign cmd_state = (state_q == S_RST1)  || (state_q == S_SKIP1) || (state_q == S_CONV) ||
                     (state_q == S_RST2)  || (state_q == S_SKIP2) || (state_q == S_RDCMD) ||
                     (state_q == S_READ);
  assign rsp_done  = cmd_state && pend_q && rsp_valid;
  assign all_zero  = (scratch_q == '0);

  // Next-state logic: sequencing, handshake tracking, counters and result capture
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    idx_d      = idx_q;
    wait_d     = wait_q;
    auto_d     = 32'd0;
    temp_d     = temp_q;
    err_code_d = err_code_q;
    scratch_d  = scratch_q;
    crc_clr    = 1'b0;
    crc_en     = 1'b0;

    if (cmd_state) begin
      if (!pend_q && cmd_ready) pend_d = 1'b1;
      else if (rsp_done)        pend_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (AUTO_EN) auto_d = auto_q + 32'd1;
        if (start || (AUTO_EN && (auto_q == AUTO_LAST))) begin
          state_d    = S_RST1;
          pend_d     = 1'b0;
          err_code_d = ERR_NONE;
          auto_d     = 32'd0;
        end
      end
      S_RST1, S_RST2: begin
        if (rsp_done) begin
          if (!rsp_presence) begin
            state_d    = S_ERR;
            err_code_d = ERR_NO_PRESENCE;
          end else begin
            state_d = (state_q == S_RST1) ? S_SKIP1 : S_SKIP2;
          end
        end
      end
      S_SKIP1: if (rsp_done) state_d = S_CONV;
      S_CONV: begin
        if (rsp_done) begin
          state_d = S_WAIT;
          wait_d  = 32'd0;
        end
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = S_RST2;
          wait_d  = 32'd0;
          crc_clr = 1'b1;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      S_SKIP2: if (rsp_done) state_d = S_RDCMD;
      S_RDCMD: begin
        if (rsp_done) begin
          state_d = S_READ;
          idx_d   = 4'd0;
        end
      end
      S_READ: begin
        if (rsp_done) begin
          scratch_d[idx_q] = rsp_data;
          crc_en           = 1'b1;
          if (idx_q == IDX_LAST) state_d = S_CHECK;
          else                   idx_d   = idx_q + 4'd1;
        end
      end
      S_CHECK: begin
        // All 9 bytes are folded in, so a correct scratchpad leaves a zero residue.
        // A floating-low bus also yields zero residue, hence the stuck test first.
        if (all_zero) begin
          state_d    = S_ERR;
          err_code_d = ERR_STUCK;
        end else if (crc_val != 8'h00) begin
          state_d    = S_ERR;
          err_code_d = ERR_CRC;
        end else begin
          state_d = S_DONE;
          temp_d  = {scratch_q[1], scratch_q[0]};
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pend_q     <= 1'b0;
      idx_q      <= 4'd0;
      wait_q     <= 32'd0;
      auto_q     <= 32'd0;
      temp_q     <= 16'h0000;
      err_code_q <= ERR_NONE;
      scratch_q  <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      idx_q      <= idx_d;
      wait_q     <= wait_d;
      auto_q     <= auto_d;
      temp_q     <= temp_d;
      err_code_q <= err_code_d;
      scratch_q  <= scratch_d;
    end
  end

  // Command request decode; op/data stay stable for the whole command state
  always_comb begin
    cmd_valid = 1'b0;
    cmd_op    = OP_RESET;
    cmd_data  = 8'h00;
    case (state_q)
      S_RST1, S_RST2: begin
        cmd_valid = !pend_q;
        cmd_op    = OP_RESET;
      end
      S_SKIP1, S_SKIP2: begin
        cmd_valid = !pend_q;
        cmd_op    = OP_WRITE;
        cmd_data  = CMD_SKIP_ROM;
      end
      S_CONV: begin
        cmd_valid = !pend_q;
        cmd_op    = OP_WRITE;
        cmd_data  = CMD_CONVERT;
      end
      S_RDCMD: begin
        cmd_valid = !pend_q;
        cmd_op    = OP_WRITE;
        cmd_data  = CMD_READ_SP;
      end
      S_READ: begin
        cmd_valid = !pend_q;
        cmd_op    = OP_READ;
      end
      default: begin
        cmd_valid = 1'b0;
      end
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign temp_valid = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  assign temp       = temp_q;
  assign err_code   = err_code_q;

endmodule

`default_nettype wire

// File: tb/tb_owr_temp_sequencer.sv
// ============================================================================
// Module : tb_owr_temp_sequencer
// Desc   : Directed bench for owr_temp_sequencer. A behavioural byte master
//          answers each command; dut runs start-pulse only, dut_auto runs
//          with AUTO_PERIOD=32 and is held in reset until the last scenario.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_owr_temp_sequencer;

  localparam logic [71:0] GOOD_SP = {8'h1C, 8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, 8'h05, 8'h50};
  localparam logic [71:0] BAD_SP  = {8'h1D, 8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, 8'h05, 8'h50};
  localparam logic [71:0] ZERO_SP = 72'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_a = 1'b1;
  logic start = 1'b0;
  logic start_a = 1'b0;
  logic cmd_ready = 1'b0;
  logic rsp_valid = 1'b0;
  logic rsp_presence = 1'b0;
  logic [7:0] rsp_data = 8'h00;
  logic sel = 1'b0;

  logic m_busy, m_tv, m_err, m_cv;
  logic [15:0] m_temp;
  logic [1:0] m_ec, m_op;
  logic [7:0] m_dat;
  logic a_busy, a_tv, a_err, a_cv;
  logic [15:0] a_temp;
  logic [1:0] a_ec, a_op;
  logic [7:0] a_dat;

  logic busy, tv, er, cv;
  logic [15:0] tmp;
  logic [1:0] ec, cop;
  logic [7:0] cdat;

  int n_checks = 0;
  int n_pass = 0;
  logic [15:0] exp_temp = 16'h0000;

  always #5 clk = ~clk;

  owr_temp_sequencer #(.CONV_WAIT_CYCLES(16), .AUTO_PERIOD(0)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(m_busy), .temp(m_temp),
    .temp_valid(m_tv), .err(m_err), .err_code(m_ec), .cmd_valid(m_cv),
    .cmd_op(m_op), .cmd_data(m_dat), .cmd_ready(cmd_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_presence(rsp_presence)
  );

  owr_temp_sequencer #(.CONV_WAIT_CYCLES(16), .AUTO_PERIOD(32)) dut_auto (
    .clk(clk), .rst(rst_a), .start(start_a), .busy(a_busy), .temp(a_temp),
    .temp_valid(a_tv), .err(a_err), .err_code(a_ec), .cmd_valid(a_cv),
    .cmd_op(a_op), .cmd_data(a_dat), .cmd_ready(cmd_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_presence(rsp_presence)
  );

  // The byte-master model talks to whichever instance is selected
  assign busy = sel ? a_busy : m_busy;
  assign tv   = sel ? a_tv   : m_tv;
  assign er   = sel ? a_err  : m_err;
  assign cv   = sel ? a_cv   : m_cv;
  assign tmp  = sel ? a_temp : m_temp;
  assign ec   = sel ? a_ec   : m_ec;
  assign cop  = sel ? a_op   : m_op;
  assign cdat = sel ? a_dat  : m_dat;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serve command i of the sequence: RST, CC, 44, RST, CC, BE, READ x9
  task automatic serve_cmd(input int i, input logic pres, input logic [7:0] rdat,
                           input int rdy_delay, input int exp_gap, input logic poke_start);
    int gap;
    logic [1:0] eop;
    logic [7:0] edat;
    logic [7:0] d0;
    eop  = (i == 0 || i == 3) ? 2'b00 : ((i <= 5) ? 2'b01 : 2'b10);
    edat = (i == 1 || i == 4) ? 8'hCC : (i == 2) ? 8'h44 : (i == 5) ? 8'hBE : 8'h00;
    gap = 0;
    while (cv !== 1'b1 && gap < 200) begin
      gap++;
      step();
    end
    n_checks++; if (cv !== 1'b1) $display("FAIL cmd%0d_valid: got %b want 1 (timeout)", i, cv); else n_pass++;
    if (exp_gap >= 0) begin
      n_checks++; if (gap !== exp_gap) $display("FAIL cmd%0d_gap: got %0d want %0d", i, gap, exp_gap); else n_pass++;
    end
    n_checks++; if (cop !== eop) $display("FAIL cmd%0d_op: got %b want %b", i, cop, eop); else n_pass++;
    if (eop == 2'b01) begin
      n_checks++; if (cdat !== edat) $display("FAIL cmd%0d_data: got %h want %h", i, cdat, edat); else n_pass++;
    end
    d0 = cdat;
    for (int k = 0; k < rdy_delay; k++) begin
      step();
      n_checks++;
      if ({cv, cop, cdat} !== {1'b1, eop, d0})
        $display("FAIL cmd%0d_stable: got %b/%b/%h want 1/%b/%h", i, cv, cop, cdat, eop, d0);
      else n_pass++;
    end
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    n_checks++; if (cv !== 1'b0) $display("FAIL cmd%0d_drop: got %b want 0", i, cv); else n_pass++;
    if (poke_start) begin
      start = 1'b1;
      step();
      start = 1'b0;
      n_checks++; if ({cv, busy} !== 2'b01) $display("FAIL start_in_read: got cv/busy %b%b want 01", cv, busy); else n_pass++;
    end else begin
      step();
    end
    step();
    rsp_valid = 1'b1; rsp_data = rdat; rsp_presence = pres;
    step();
    rsp_valid = 1'b0; rsp_data = 8'h00; rsp_presence = 1'b0;
  endtask

  // One full measurement, then the outcome pulse and return to idle
  task automatic do_meas(input logic do_start, input logic pres, input logic [71:0] sp,
                         input int rdy, input logic poke, input logic exp_ok, input logic [1:0] exp_ec);
    int ncmd;
    int lat;
    int eg;
    logic [7:0] rd;
    if (do_start) begin
      start = 1'b1;
      step();
      start = 1'b0;
      n_checks++; if (busy !== 1'b1) $display("FAIL start_busy: got %b want 1", busy); else n_pass++;
      n_checks++; if (ec !== 2'b00) $display("FAIL start_ec_clear: got %b want 00", ec); else n_pass++;
    end
    ncmd = pres ? 15 : 1;
    for (int i = 0; i < ncmd; i++) begin
      eg = (!do_start && i == 0) ? -1 : ((i == 3) ? 16 : 0);
      rd = (i >= 6) ? sp[(i-6)*8 +: 8] : 8'h00;
      serve_cmd(i, pres, rd, rdy, eg, poke && (i == 8));
    end
    lat = 1;
    while (tv !== 1'b1 && er !== 1'b1 && lat < 10) begin
      step();
      lat++;
    end
    if (exp_ok) exp_temp = sp[15:0];
    n_checks++; if (lat !== (pres ? 2 : 1)) $display("FAIL end_latency: got %0d want %0d", lat, pres ? 2 : 1); else n_pass++;
    n_checks++; if ({tv, er} !== {exp_ok, !exp_ok}) $display("FAIL outcome: got tv/err %b%b want %b%b", tv, er, exp_ok, !exp_ok); else n_pass++;
    n_checks++; if (ec !== exp_ec) $display("FAIL err_code: got %b want %b", ec, exp_ec); else n_pass++;
    n_checks++; if (tmp !== exp_temp) $display("FAIL temp: got %h want %h", tmp, exp_temp); else n_pass++;
    step();
    n_checks++;
    if ({busy, tv, er, ec} !== {3'b000, exp_ec})
      $display("FAIL after_end: got busy/tv/err/ec %b%b%b%b want 000%b", busy, tv, er, ec, exp_ec);
    else n_pass++;
  endtask

  // Idle check: no command may appear without a new start
  task automatic check_quiet(input string name);
    int seen;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (cv === 1'b1 || busy === 1'b1) seen++;
      step();
    end
    n_checks++; if (seen !== 0) $display("FAIL %s: got %0d active cycles want 0", name, seen); else n_pass++;
  endtask

  task automatic test_reset();
    repeat (3) step();
    rst = 1'b0;
    n_checks++;
    if ({busy, tv, er, ec, cv, cop} !== 8'h00) $display("FAIL reset_ctrl: got %b%b%b%b%b%b want 0", busy, tv, er, ec, cv, cop);
    else n_pass++;
    n_checks++; if ({tmp, cdat} !== 24'h0) $display("FAIL reset_data: got %h/%h want 0000/00", tmp, cdat); else n_pass++;
    check_quiet("reset_idle");
  endtask

  task automatic test_good();
    do_meas(1'b1, 1'b1, GOOD_SP, 0, 1'b0, 1'b1, 2'b00);
  endtask

  task automatic test_crc_fail();
    do_meas(1'b1, 1'b1, BAD_SP, 0, 1'b0, 1'b0, 2'b10);
  endtask

  task automatic test_no_presence();
    do_meas(1'b1, 1'b0, GOOD_SP, 0, 1'b0, 1'b0, 2'b01);
    check_quiet("no_presence_quiet");
  endtask

  task automatic test_all_zero();
    do_meas(1'b1, 1'b1, ZERO_SP, 0, 1'b0, 1'b0, 2'b11);
  endtask

  task automatic test_ready_stall();
    do_meas(1'b1, 1'b1, GOOD_SP, 5, 1'b0, 1'b1, 2'b00);
  endtask

  task automatic test_start_in_read();
    do_meas(1'b1, 1'b1, GOOD_SP, 0, 1'b1, 1'b1, 2'b00);
    check_quiet("start_not_queued");
  endtask

  task automatic test_rst_in_wait();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) serve_cmd(i, 1'b1, 8'h00, 0, 0, 1'b0);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_temp = 16'h0000;
    n_checks++;
    if ({busy, tv, er, ec, cv, cop} !== 8'h00) $display("FAIL rst_wait_ctrl: got %b%b%b%b%b%b want 0", busy, tv, er, ec, cv, cop);
    else n_pass++;
    n_checks++; if ({tmp, cdat} !== 24'h0) $display("FAIL rst_wait_data: got %h/%h want 0000/00", tmp, cdat); else n_pass++;
    step();
    n_checks++; if (cv !== 1'b0) $display("FAIL rst_wait_cv: got %b want 0", cv); else n_pass++;
    do_meas(1'b1, 1'b1, GOOD_SP, 0, 1'b0, 1'b1, 2'b00);
  endtask

  task automatic test_auto();
    int gap;
    sel = 1'b1;
    exp_temp = 16'h0000;
    rst_a = 1'b0;
    do_meas(1'b0, 1'b1, GOOD_SP, 0, 1'b0, 1'b1, 2'b00);
    gap = 0;
    while (cv !== 1'b1 && gap < 200) begin
      gap++;
      step();
    end
    n_checks++; if (gap !== 32) $display("FAIL auto_restart_gap: got %0d want 32", gap); else n_pass++;
    n_checks++; if ({busy, cop} !== 3'b100) $display("FAIL auto_restart_cmd: got busy/op %b%b want 100", busy, cop); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_good();
    test_crc_fail();
    test_no_presence();
    test_all_zero();
    test_ready_stall();
    test_start_in_read();
    test_rst_in_wait();
    test_auto();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/owr_temp_sequencer.md
Name: owr_temp_sequencer

Overview:
Controller that sequences a byte-level one-wire master to run DS18B20-style temperature measurements: bus reset and presence check, SKIP ROM, CONVERT T, conversion wait, second reset, SKIP ROM, READ SCRATCHPAD. It collects the 9 scratchpad bytes, checks them with CRC-8 and publishes the raw 16-bit temperature. It sits between the LED/display logic of the temperature design and the one-wire byte master, which owns all bus timing.

Parameters:
CONV_WAIT_CYCLES, 9000000, clk cycles to wait after CONVERT T (750 ms at 12 MHz); simulation uses 16
AUTO_PERIOD, 0, if nonzero, cycles from DONE/ERR back to an automatic start; 0 means start-pulse only

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a measurement
busy  out  1  high from accepted start until DONE/ERR
temp  out  16  raw signed temperature {byte1,byte0}, 1/16 degC LSB; holds last good value
temp_valid  out  1  one-cycle pulse when temp updates
err  out  1  one-cycle pulse on failed measurement
err_code  out  2  00 none, 01 no presence, 10 CRC fail, 11 bus stuck (all bytes 0x00); held until next start
cmd_valid  out  1  command request to byte master
cmd_op  out  2  00 bus reset, 01 write byte, 10 read byte
cmd_data  out  8  byte to write (don't-care for other ops)
cmd_ready  in  1  master accepts command when cmd_valid & cmd_ready
rsp_valid  in  1  one-cycle completion pulse from master
rsp_data  in  8  byte read (valid with rsp_valid, read op)
rsp_presence  in  1  presence detected (valid with rsp_valid, reset op)

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: busy=0, temp=16'h0000, temp_valid=0, err=0, err_code=00, cmd_valid=0, cmd_op=00, cmd_data=8'h00; FSM=IDLE; wait and auto counters=0.
- States: IDLE -> RST1 -> SKIP1(0xCC) -> CONV(0x44) -> WAIT -> RST2 -> SKIP2(0xCC) -> RDCMD(0xBE) -> READ(x9) -> CHECK -> DONE or ERR -> IDLE.
- IDLE: start=1, or auto timer expiry when AUTO_PERIOD!=0, moves to RST1 next cycle. busy=1 from that cycle. err_code clears to 00.
- Command states: assert cmd_valid with stable op/data until the cycle cmd_valid&cmd_ready. Then drop cmd_valid and wait for rsp_valid. Exactly one command is outstanding. The next command may assert no earlier than the cycle after rsp_valid.
- rsp_valid while no command is outstanding: ignored.
- RST1/RST2: rsp_presence=0 -> ERR with code 01.
- WAIT: counter counts CONV_WAIT_CYCLES cycles, then RST2. No bus activity during WAIT.
- READ: 9 read-byte commands. Byte index 0..8 stored LSB-first. Each byte is fed to the CRC unit on its rsp_valid.
- CHECK: one cycle.
  - All 9 bytes 0x00 -> ERR code 11. This takes precedence over the CRC result.
  - Otherwise CRC-8 over bytes 0..7 != byte 8 -> ERR code 10.
  - Otherwise -> DONE.
- DONE: temp <= {b1,b0}; temp_valid=1 for one cycle; busy=0 next cycle.
- ERR: err=1 for one cycle, err_code set, temp unchanged, busy=0 next cycle.
- start while busy: ignored; not queued.
- rst mid-operation: immediate return to reset values next edge. The master is expected to be reset by the same rst.
- Auto mode: counter restarts on entering IDLE. An explicit start in IDLE preempts it.

Decomposition:
- Package owr_pkg:
  - cmd_op encodings
  - ROM/function constants CMD_SKIP_ROM=8'hCC, CMD_CONVERT=8'h44, CMD_READ_SP=8'hBE
  - err_code encodings
  - FSM state enum
  - SCRATCH_BYTES=9
- Sub-module owr_crc8: Dallas/Maxim CRC-8, poly x^8+x^5+x^4+1, reflected, byte-serial.
  - Inputs: clk, rst, clr, en, data[7:0].
  - Output: crc[7:0].
  - Cleared on entry to RST2.

Test Plan:
- Power-on scratchpad: presence=1 and bytes 50 05 4B 46 7F FF 0C 10 1C -> temp=16'h0550, temp_valid pulse, err_code=00. Command sequence is RST, CC, 44, RST, CC, BE, 9x READ.
- Same sequence, last byte 0x1D -> err pulse, err_code=10, temp keeps its prior value.
- rsp_presence=0 on first reset -> ERR code 01 immediately. No write commands issued.
- All 9 bytes 0x00 -> err_code=11, not DONE.
- CONV_WAIT_CYCLES=16, cmd_ready held low 5 cycles -> cmd_valid/op/data stable throughout. Exactly 16 idle cycles between CONVERT rsp_valid and RST2 cmd_valid.
- Two further checks, both with cmd_valid=0 the next cycle:
  - start during READ -> ignored.
  - rst asserted during WAIT -> all outputs at reset values the next cycle.
  - Then a new start completes normally; AUTO_PERIOD=32 restarts 32 cycles after DONE.
